// File: rtl/slot_reel_engine.sv
// slot_reel_engine: LFSR-seeded multi-reel spinner with staggered stop and registered win flags
module slot_reel_engine #(
  parameter int NUM_REELS = 3,
  parameter int DIGIT_W = 3,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter int SPIN_DIV = 4,
  parameter int STOP_GAP = 30,
  parameter int AUTO_STOP = 600
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         tick_en,
  input  logic                         spin,
  input  logic                         stop,
  output logic [NUM_REELS*DIGIT_W-1:0] reel_digits,
  output logic [NUM_REELS-1:0]         reel_spinning,
  output logic                         busy,
  output logic                         result_valid,
  output logic                         win_all,
  output logic                         win_pair
);
  localparam int SW = $clog2(SPIN_DIV + 1);
  localparam int AW = $clog2(AUTO_STOP + 2);
  localparam int GW = $clog2(NUM_REELS * STOP_GAP + 2);
  typedef enum logic [1:0] {IDLE, SPIN, STOPPING, RESULT} state_t;
  state_t state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [NUM_REELS*DIGIT_W-1:0] digits_q, digits_d;
  logic [NUM_REELS-1:0] spinning_q, spinning_d;
  logic [SW-1:0] step_q, step_d;
  logic [AW-1:0] auto_q, auto_d;
  logic [GW-1:0] gap_q, gap_d;
  logic win_all_q, win_all_d, win_pair_q, win_pair_d;
  logic fb, tick_step, auto_hit, all_eq, any_eq;
  if (LFSR_W == 32) begin : g_l32
    assign fb = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
  end else if (LFSR_W == 24) begin : g_l24
    assign fb = lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16];
  end else begin : g_l16
    assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end
  // Compare the frozen digits: all equal to reel 0, or any pair equal
  always_comb begin
    all_eq = 1'b1;
    any_eq = 1'b0;
    for (int i = 0; i < NUM_REELS; i++)
      for (int j = i + 1; j < NUM_REELS; j++) begin
        if (digits_q[i*DIGIT_W +: DIGIT_W] == digits_q[j*DIGIT_W +: DIGIT_W]) any_eq = 1'b1;
        if (i == 0 && digits_q[j*DIGIT_W +: DIGIT_W] != digits_q[0 +: DIGIT_W]) all_eq = 1'b0;
      end
  end
  // Next-state: reel stepping, spin load, stop staggering and result capture
  always_comb begin
    state_d = state_q;
    lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    digits_d = digits_q;
    spinning_d = spinning_q;
    step_d = step_q;
    auto_d = auto_q;
    gap_d = gap_q;
    win_all_d = win_all_q;
    win_pair_d = win_pair_q;
    tick_step = tick_en && int'(step_q) == SPIN_DIV - 1;
    auto_hit = AUTO_STOP != 0 && tick_en && int'(auto_q) == AUTO_STOP - 1;
    if (state_q == SPIN || state_q == STOPPING) begin
      if (tick_en) step_d = tick_step ? '0 : step_q + 1'b1;
      for (int i = 0; i < NUM_REELS; i++)
        if (tick_step && spinning_q[i]) digits_d[i*DIGIT_W +: DIGIT_W] = digits_q[i*DIGIT_W +: DIGIT_W] + 1'b1;
    end
    if ((state_q == IDLE || state_q == RESULT) && spin) begin
      state_d = SPIN;
      digits_d = lfsr_q[NUM_REELS*DIGIT_W-1:0];
      spinning_d = '1;
      step_d = '0;
      auto_d = '0;
      gap_d = '0;
      win_all_d = 1'b0;
      win_pair_d = 1'b0;
    end else if (state_q == SPIN) begin
      if (tick_en) auto_d = auto_q + 1'b1;
      if (stop || auto_hit) begin
        state_d = STOPPING;
        gap_d = '0;
        for (int i = 0; i < NUM_REELS; i++)
          if (i * STOP_GAP == 0) spinning_d[i] = 1'b0;
      end
    end else if (state_q == STOPPING) begin
      if (spinning_q == '0) begin
        state_d = RESULT;
        win_all_d = all_eq;
        win_pair_d = any_eq && !all_eq;
      end else begin
        if (tick_en) gap_d = gap_q + 1'b1;
        for (int i = 0; i < NUM_REELS; i++)
          if (int'(gap_q) == i * STOP_GAP) spinning_d[i] = 1'b0;
      end
    end
  end
  // State register; clr aborts any spin and discards the result
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      digits_q <= '0;
      spinning_q <= '0;
      step_q <= '0;
      auto_q <= '0;
      gap_q <= '0;
      win_all_q <= 1'b0;
      win_pair_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      digits_q <= digits_d;
      spinning_q <= spinning_d;
      step_q <= step_d;
      auto_q <= auto_d;
      gap_q <= gap_d;
      win_all_q <= win_all_d;
      win_pair_q <= win_pair_d;
    end
  assign reel_digits = digits_q;
  assign reel_spinning = spinning_q;
  assign busy = state_q == SPIN || state_q == STOPPING;
  assign result_valid = state_q == RESULT;
  assign win_all = win_all_q;
  assign win_pair = win_pair_q;
endmodule

// File: tb/tb_slot_reel_engine.sv
// tb_slot_reel_engine: scoreboard bench for slot_reel_engine
module tb_slot_reel_engine;
  logic clk = 1'b0, clr = 1'b1, tick_en = 1'b0;
  logic spin_a = 1'b0, stop_a = 1'b0, spin_w = 1'b0, stop_w = 1'b0;
  wire [8:0] dg [4];
  wire [2:0] rs [4];
  wire bz [4], rv [4], wa [4], wp [4];
  logic rv_prev [4] = '{default: 1'b0};
  logic [15:0] m;
  int checks = 0, errors = 0;
  typedef struct {int id; logic [8:0] d; logic a; logic p;} exp_t;
  exp_t sb [$];
  exp_t e_mon;
  always #5 clk = ~clk;
  slot_reel_engine #(.SPIN_DIV(1), .STOP_GAP(2), .AUTO_STOP(10)) u_a (
    .clk(clk), .clr(clr), .tick_en(tick_en), .spin(spin_a), .stop(stop_a),
    .reel_digits(dg[0]), .reel_spinning(rs[0]), .busy(bz[0]), .result_valid(rv[0]),
    .win_all(wa[0]), .win_pair(wp[0]));
  for (genvar g = 1; g < 4; g++) begin : g_w
    slot_reel_engine #(.SEED(g == 1 ? 16'h016D : g == 2 ? 16'h00AD : 16'h00D1), .STOP_GAP(0), .AUTO_STOP(0)) u_w (
      .clk(clk), .clr(clr), .tick_en(tick_en), .spin(spin_w), .stop(stop_w),
      .reel_digits(dg[g]), .reel_spinning(rs[g]), .busy(bz[g]), .result_valid(rv[g]),
      .win_all(wa[g]), .win_pair(wp[g]));
  end
  // Reference LFSR for instance A, taps 16,14,13,11
  always @(posedge clk or posedge clr) m <= clr ? 16'hACE1 : {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  function automatic logic [8:0] add3(logic [8:0] d, int a0, int a1, int a2);
    return {d[8:6] + 3'(a2), d[5:3] + 3'(a1), d[2:0] + 3'(a0)};
  endfunction
  function automatic exp_t mk(int id, logic [8:0] d);
    logic ae = d[2:0] == d[5:3] && d[5:3] == d[8:6];
    return '{id, d, ae, !ae && (d[2:0] == d[5:3] || d[2:0] == d[8:6] || d[5:3] == d[8:6])};
  endfunction
  task automatic tick();
    tick_en = 1'b1;
    @(negedge clk);
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  // Monitor: every rising result_valid pops one expected result
  always @(negedge clk)
    for (int k = 0; k < 4; k++) begin
      if (rv[k] && !rv_prev[k]) begin
        if (sb.size() == 0) chk($sformatf("unexpected_result%0d", k), 1, 0);
        else begin
          e_mon = sb.pop_front();
          chk("result_id", k, e_mon.id);
          chk("result_digits", dg[k], e_mon.d);
          chk("result_win_all", wa[k], e_mon.a);
          chk("result_win_pair", wp[k], e_mon.p);
        end
      end
      rv_prev[k] <= rv[k];
    end
  initial begin
    logic [8:0] ld;
    repeat (2) @(negedge clk);
    chk("rst_digits", dg[0], 0);
    chk("rst_outs", {rs[0], bz[0], rv[0], wa[0], wp[0]}, 0);
    clr = 1'b0;
    spin_w = 1'b1;
    sb.push_back('{1, 9'h16D, 1'b1, 1'b0});
    sb.push_back('{2, 9'h0AD, 1'b0, 1'b1});
    sb.push_back('{3, 9'h0D1, 1'b0, 1'b0});
    @(negedge clk);
    spin_w = 1'b0;
    stop_w = 1'b1;
    chk("win_load", dg[1], 9'h16D);
    chk("win_load_busy", bz[1], 1);
    @(negedge clk);
    stop_w = 1'b0;
    chk("gap0_freeze", {rs[1], rs[2], rs[3]}, 0);
    @(negedge clk);
    chk("win_rv", rv[1], 1);
    spin_w = 1'b1;
    @(negedge clk);
    spin_w = 1'b0;
    chk("respin_flags_clear", {wa[1], wp[2], rv[1], bz[1]}, 4'b0001);
    ld = m[8:0];
    spin_a = 1'b1;
    @(negedge clk);
    spin_a = 1'b0;
    chk("load_digits", dg[0], ld);
    chk("load_spin", rs[0], 3'b111);
    chk("load_busy", {bz[0], rv[0]}, 2'b10);
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk($sformatf("step%0d", t), dg[0], add3(ld, t, t, t));
    end
    stop_a = 1'b1;
    sb.push_back(mk(0, add3(ld, 8, 10, 12)));
    @(negedge clk);
    stop_a = 1'b0;
    chk("stop_reel0", rs[0], 3'b110);
    tick();
    tick();
    chk("stagger_reel1", rs[0], 3'b100);
    tick();
    tick_en = 1'b1;
    @(negedge clk);
    tick_en = 1'b0;
    chk("pre_freeze2", rs[0], 3'b100);
    @(negedge clk);
    chk("freeze2", {rs[0], bz[0], rv[0]}, 5'b00010);
    @(negedge clk);
    chk("result_rise", {bz[0], rv[0]}, 2'b01);
    ld = m[8:0];
    spin_a = 1'b1;
    @(negedge clk);
    spin_a = 1'b0;
    chk("respin_load", dg[0], ld);
    chk("respin_clear", {rv[0], wa[0], wp[0], bz[0]}, 4'b0001);
    tick();
    spin_a = 1'b1;
    @(negedge clk);
    spin_a = 1'b0;
    chk("spin_ignored", dg[0], add3(ld, 1, 1, 1));
    repeat (8) tick();
    chk("pre_auto", {rs[0], bz[0]}, 4'b1111);
    tick_en = 1'b1;
    @(negedge clk);
    tick_en = 1'b0;
    chk("auto_stop", rs[0], 3'b110);
    chk("auto_freeze_val", dg[0], add3(ld, 10, 10, 10));
    tick();
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    tick();
    chk("stop_in_stopping", rs[0], 3'b100);
    sb.push_back(mk(0, add3(ld, 10, 12, 14)));
    tick();
    tick();
    for (int w = 0; w < 20 && !rv[0]; w++) @(negedge clk);
    chk("auto_result", rv[0], 1);
    spin_a = 1'b1;
    @(negedge clk);
    spin_a = 1'b0;
    tick();
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    tick();
    chk("abort_pre", {bz[0], rs[0]}, 4'b1110);
    #2 clr = 1'b1;
    #1;
    chk("abort_digits", dg[0], 0);
    chk("abort_outs", {rs[0], bz[0], rv[0], wa[0], wp[0]}, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_result", rv[0], 0);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
